// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch queue: state encoding,
// default widths and instruction constants.
package inst_fetch_queue_pkg;

    localparam int DATA_W_DEF = 32;

    // Canonical RISC-V NOP (addi x0, x0, 0), kept here for future bubble insertion.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} pairs for decode.
// Clear empties the queue in one cycle and wins over push and pop.
module fetch_fifo
    import inst_fetch_queue_pkg::*;
#(
    parameter int WIDTH = 2 * DATA_W_DEF,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Guard against overflow/underflow even though the fetch FSM never requests them.
    assign do_push = push_i && !clear_i && (count_q != FULL_CNT);
    assign do_pop  = pop_i  && !clear_i && (count_q != '0);

    // Next-state pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2).
    always_comb begin
        // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; write at the tail on an accepted push.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is reset so the head outputs read as zero out of reset rather than X.
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch stage: one outstanding imem request, a small queue of
// {pc, instr} pairs toward decode, PC-advance control and flush handling.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [DATA_W-1:0] iv_Pc,
    output logic              o_PcEnb,
    output logic              o_MemReq,
    output logic [DATA_W-1:0] ov_MemAddr,
    input  logic              i_MemAck,
    input  logic [DATA_W-1:0] iv_MemRdata,
    input  logic              i_Flush,
    output logic              o_Valid,
    output logic [DATA_W-1:0] ov_Instr,
    output logic [DATA_W-1:0] ov_InstrPc,
    input  logic              i_Ready
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_state_e        state_q;
    logic                mem_req_q;
    logic [DATA_W-1:0]   drop_addr_q;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_d;
    logic [2*DATA_W-1:0] head;
    logic                accept;
    logic                pop;

    // A response is kept only when it answers a live request that is not being flushed.
    assign accept  = (state_q == ST_REQ) && i_MemAck && !i_Flush && !i_Rst;
    assign pop     = o_Valid && i_Ready && !i_Flush;
    assign count_d = count + CNT_W'(accept) - CNT_W'(pop);

    fetch_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i   (i_Clk),
        .rst_i   (i_Rst),
        .clear_i (i_Flush),
        .push_i  (accept),
        .wdata_i ({iv_Pc, iv_MemRdata}),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count)
    );

    // Fetch FSM: launches a request only when the queue has room, drains a flushed fetch in DROP.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            drop_addr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!i_Flush && (count < FULL_CNT)) begin
                        state_q   <= ST_REQ;
                        mem_req_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (i_Flush) begin
                        if (i_MemAck) begin
                            state_q   <= ST_IDLE;
                            mem_req_q <= 1'b0;
                        end else begin
                            // imem still owes us a response for the old address; keep asking for it.
                            state_q     <= ST_DROP;
                            drop_addr_q <= iv_Pc;
                        end
                    end else if (i_MemAck && (count_d >= FULL_CNT)) begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                ST_DROP: begin
                    if (i_MemAck) begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Request address: live PC while fetching, frozen address while draining.
    always_comb begin
        ov_MemAddr = '0;
        case (state_q)
            ST_REQ:  ov_MemAddr = iv_Pc;
            ST_DROP: ov_MemAddr = drop_addr_q;
            default: ov_MemAddr = '0;
        endcase
    end

    assign o_MemReq   = mem_req_q;
    assign o_PcEnb    = accept;
    assign o_Valid    = (count != '0);
    assign ov_InstrPc = head[2*DATA_W-1:DATA_W];
    assign ov_Instr   = head[DATA_W-1:0];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios with literal
// expectations, then randomized traffic checked against a queue-based model.
module tb_inst_fetch_queue;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        ack;
    logic [31:0] rdata;
    logic        flush;
    logic        ready;
    logic [31:0] redir_pc;

    logic        pc_enb;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: queue contents plus the outstanding-request status.
    ent_t        m_q[$];
    bit          m_req      = 1'b0;
    bit          m_drop     = 1'b0;
    logic [31:0] m_drop_addr = '0;

    always #5 clk = ~clk;

    inst_fetch_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .iv_Pc       (pc),
        .o_PcEnb     (pc_enb),
        .o_MemReq    (mem_req),
        .ov_MemAddr  (mem_addr),
        .i_MemAck    (ack),
        .iv_MemRdata (rdata),
        .i_Flush     (flush),
        .o_Valid     (valid),
        .ov_Instr    (instr),
        .ov_InstrPc  (instr_pc),
        .i_Ready     (ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare DUT against the model mid-cycle, advance the model,
    // cross the edge, then update the bench's PC register.
    task automatic step();
        bit          e_req, e_pcenb, e_valid, e_pop;
        logic [31:0] e_addr;
        int          old_size;
        ent_t        e;
        #4;
        e_valid = (m_q.size() != 0);
        e_req   = m_req;
        e_addr  = !m_req ? 32'h0 : (m_drop ? m_drop_addr : pc);
        e_pcenb = m_req && !m_drop && ack && !flush && !rst;
        check("mem_req",  32'(mem_req), 32'(e_req));
        check("mem_addr", mem_addr, e_addr);
        check("pc_enb",   32'(pc_enb), 32'(e_pcenb));
        check("valid",    32'(valid), 32'(e_valid));
        if (e_valid) begin
            check("instr",    instr,    m_q[0].instr);
            check("instr_pc", instr_pc, m_q[0].pc);
        end

        old_size = m_q.size();
        e_pop    = e_valid && ready && !flush;
        if (rst) begin
            m_q.delete();
            m_req  = 1'b0;
            m_drop = 1'b0;
        end else begin
            if (flush) m_q.delete();
            else begin
                if (e_pop) void'(m_q.pop_front());
                if (e_pcenb) begin
                    e.pc    = pc;
                    e.instr = rdata;
                    m_q.push_back(e);
                end
            end
            if (!m_req) m_req = !flush && (old_size < DEPTH);
            else if (m_drop) begin
                if (ack) begin
                    m_req  = 1'b0;
                    m_drop = 1'b0;
                end
            end else if (flush) begin
                if (ack) m_req = 1'b0;
                else begin
                    m_drop      = 1'b1;
                    m_drop_addr = pc;
                end
            end else if (ack) m_req = (m_q.size() < DEPTH);
        end

        @(posedge clk);
        #1;
        if (flush) pc = redir_pc;
        else if (e_pcenb) pc = pc + 32'd4;
    endtask

    initial begin
        rst = 1'b1; pc = '0; ack = 1'b0; rdata = '0;
        flush = 1'b0; ready = 1'b0; redir_pc = '0;

        // 1: reset and release
        @(posedge clk);
        #1;
        check("rst_req",    32'(mem_req), 32'h0);
        check("rst_valid",  32'(valid), 32'h0);
        check("rst_instr",  instr, 32'h0);
        check("rst_ipc",    instr_pc, 32'h0);
        check("rst_addr",   mem_addr, 32'h0);
        check("rst_pcenb",  32'(pc_enb), 32'h0);
        step();
        rst = 1'b0;
        check("idle_req", 32'(mem_req), 32'h0);
        step();
        check("first_req",  32'(mem_req), 32'h1);
        check("first_addr", mem_addr, 32'h0);

        // 2: streaming, one fetch per cycle
        for (int k = 0; k < 4; k++) begin
            ack = 1'b1; rdata = 32'h1000 + k; ready = 1'b1;
            #1;
            check("stream_pcenb", 32'(pc_enb), 32'h1);
            check("stream_addr",  mem_addr, 32'(4 * k));
            step();
            check("stream_valid", 32'(valid), 32'h1);
            check("stream_ipc",   instr_pc, 32'(4 * k));
            check("stream_instr", instr, 32'h1000 + k);
        end
        ack = 1'b0;
        step();
        check("stream_empty", 32'(valid), 32'h0);

        // 3: fill to capacity, then one pop restarts fetching
        ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ack = 1'b1; rdata = 32'h2000 + k;
            step();
        end
        check("full_req",   32'(mem_req), 32'h0);
        check("full_valid", 32'(valid), 32'h1);
        check("full_ipc",   instr_pc, 32'h10);
        ack = 1'b0;
        #1;
        check("full_pcenb", 32'(pc_enb), 32'h0);
        ready = 1'b1;
        step();
        check("pop_ipc", instr_pc, 32'h14);
        ready = 1'b0;
        step();
        check("refetch_req",  32'(mem_req), 32'h1);
        check("refetch_addr", mem_addr, 32'h20);
        ready = 1'b1;
        repeat (3) step();
        check("drain_valid", 32'(valid), 32'h0);

        // 4: flush with a late response goes through DROP
        ready = 1'b0; flush = 1'b1; redir_pc = 32'h100;
        #1;
        check("flush_pcenb", 32'(pc_enb), 32'h0);
        step();
        flush = 1'b0;
        check("drop_req",   32'(mem_req), 32'h1);
        check("drop_addr",  mem_addr, 32'h20);
        check("drop_valid", 32'(valid), 32'h0);
        repeat (2) step();
        check("drop_hold", mem_addr, 32'h20);
        ack = 1'b1; rdata = 32'hDEAD_BEEF;
        #1;
        check("drop_pcenb", 32'(pc_enb), 32'h0);
        step();
        ack = 1'b0;
        check("drop_idle",  32'(mem_req), 32'h0);
        check("drop_empty", 32'(valid), 32'h0);
        step();
        check("redir_addr", mem_addr, 32'h100);

        // 5: flush, ack and pop together with two entries queued
        for (int k = 0; k < 2; k++) begin
            ack = 1'b1; rdata = 32'h3000 + k;
            step();
        end
        check("two_ipc", instr_pc, 32'h100);
        flush = 1'b1; redir_pc = 32'h200; ready = 1'b1;
        #1;
        check("ffa_pcenb", 32'(pc_enb), 32'h0);
        step();
        flush = 1'b0; ack = 1'b0; ready = 1'b0;
        check("ffa_valid", 32'(valid), 32'h0);
        check("ffa_idle",  32'(mem_req), 32'h0);
        step();
        check("ffa_req",  32'(mem_req), 32'h1);
        check("ffa_addr", mem_addr, 32'h200);

        // 6: push and pop in the same cycle at count 3
        for (int k = 0; k < 3; k++) begin
            ack = 1'b1; rdata = 32'h4000 + k;
            step();
        end
        check("c3_req", 32'(mem_req), 32'h1);
        check("c3_ipc", instr_pc, 32'h200);
        ready = 1'b1; rdata = 32'h4003;
        #1;
        check("c3_pcenb", 32'(pc_enb), 32'h1);
        step();
        check("c3_req_after", 32'(mem_req), 32'h1);
        check("c3_head_adv",  instr_pc, 32'h204);
        ready = 1'b0; rdata = 32'h4004;
        step();
        check("c3_now_full", 32'(mem_req), 32'h0);
        ack = 1'b0; ready = 1'b1;
        repeat (4) step();
        check("c3_drained", 32'(valid), 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 399) == 0);
            flush    = ($urandom_range(0, 11) == 0);
            redir_pc = $urandom & 32'hFFFF_FFFC;
            ready    = ($urandom_range(0, 2) != 0);
            ack      = m_req && !rst && ($urandom_range(0, 2) != 0);
            rdata    = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
